// File: rtl/agc_spi_pkg.sv
// Shared definitions for the AGC SPI transaction sequencer: FSM state
// encoding, transfer direction constants and the command byte layout.
package agc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Command byte sent ahead of the data byte: direction in the MSB,
  // register address in the low seven bits.
  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
  } cmd_byte_t;

  function automatic logic [7:0] cmd_byte(input logic rw, input logic [6:0] addr);
    cmd_byte_t c;
    c.rw   = rw;
    c.addr = addr;
    return c;
  endfunction

endpackage

// File: rtl/agc_spi_sequencer_if.sv
// Request/response channel between the AGC gain loop (master) and the
// SPI transaction sequencer (slave).
interface agc_spi_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_chan;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, req_chan,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, req_chan,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/agc_spi_sequencer.sv
// AGC SPI transaction sequencer. Takes one register read/write request at a
// time, frames it with chip-select setup and idle gaps around the byte
// shifter, waits for the shifter's done flag (or times out) and returns the
// read byte plus an error flag as a one-cycle response pulse.
module agc_spi_sequencer
  import agc_spi_pkg::*;
#(
  parameter int CS_SETUP = 2,
  parameter int CS_IDLE  = 4,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 7
) (
  input  logic                spi_clk,
  input  logic                reg_reset,
  agc_spi_sequencer_if.slave  req_if,
  output logic                spi_cs,
  output logic [7:0]          spi_mode,
  output logic [7:0]          spi_dataA,
  output logic                sig_R1W0,
  output logic                channel,
  input  logic                spi_done,
  input  logic [7:0]          read_data,
  output logic                busy
);

  // Terminal counts of the shared gap/timeout counter for each state.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             cs_reg, cs_next;
  logic [7:0]       mode_reg, mode_next;
  logic [7:0]       data_reg, data_next;
  logic             rw_reg, rw_next;
  logic             chan_reg, chan_next;
  logic             ready_reg, ready_next;
  logic             busy_reg, busy_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [7:0]       rsp_rdata_reg, rsp_rdata_next;
  logic             rsp_err_reg, rsp_err_next;

  // Saturating increment so the counter can never wrap back into range
  // while sitting in a state.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

  // Register every output together with the state so nothing downstream
  // sees combinational glitches; reset drops any transfer in flight.
  always_ff @(posedge spi_clk or negedge reg_reset) begin
    if (!reg_reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cs_reg        <= 1'b1;
      mode_reg      <= 8'h00;
      data_reg      <= 8'h00;
      rw_reg        <= RW_WRITE;
      chan_reg      <= 1'b0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 8'h00;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cs_reg        <= cs_next;
      mode_reg      <= mode_next;
      data_reg      <= data_next;
      rw_reg        <= rw_next;
      chan_reg      <= chan_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  // Next-state and next-output logic; the counter is cleared on every
  // state change and otherwise free-runs (saturating).
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_inc;
    cs_next        = cs_reg;
    mode_next      = mode_reg;
    data_next      = data_reg;
    rw_next        = rw_reg;
    chan_next      = chan_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;

    case (state_reg)
      IDLE: begin
        if (req_if.req_valid && ready_reg) begin
          mode_next  = cmd_byte(req_if.req_rw, req_if.req_addr);
          data_next  = req_if.req_wdata;
          rw_next    = req_if.req_rw;
          chan_next  = req_if.req_chan;
          cs_next    = 1'b0;
          cnt_next   = '0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          cnt_next   = '0;
          state_next = XFER;
        end
      end
      XFER: begin
        // Done is checked first so a completion on the last timeout
        // cycle still counts as a good transfer.
        if (spi_done) begin
          rsp_rdata_next = (rw_reg == RW_READ) ? read_data : 8'h00;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          cs_next        = 1'b1;
          cnt_next       = '0;
          state_next     = HOLD;
        end else if (cnt_reg == TO_LAST) begin
          rsp_rdata_next = 8'h00;
          rsp_err_next   = 1'b1;
          rsp_valid_next = 1'b1;
          cs_next        = 1'b1;
          cnt_next       = '0;
          state_next     = HOLD;
        end
      end
      HOLD: begin
        if (cnt_reg == IDLE_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        cs_next    = 1'b1;
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    ready_next = (state_next == IDLE);
    busy_next  = (state_next != IDLE);
  end

  assign spi_cs           = cs_reg;
  assign spi_mode         = mode_reg;
  assign spi_dataA        = data_reg;
  assign sig_R1W0         = rw_reg;
  assign channel          = chan_reg;
  assign busy             = busy_reg;
  assign req_if.req_ready = ready_reg;
  assign req_if.rsp_valid = rsp_valid_reg;
  assign req_if.rsp_rdata = rsp_rdata_reg;
  assign req_if.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_agc_spi_sequencer.sv
// Testbench for agc_spi_sequencer: table of single transactions (writes,
// reads, timeouts, done on the last timeout cycle) plus hand-written
// back-to-back and mid-transfer reset sequences.
module tb_agc_spi_sequencer;
  import agc_spi_pkg::*;

  localparam int CS_SETUP = 2;
  localparam int CS_IDLE  = 4;
  localparam int TIMEOUT  = 64;
  localparam int CNT_W    = 7;

  logic       clk;
  logic       rst_n;
  logic       spi_cs;
  logic [7:0] spi_mode;
  logic [7:0] spi_dataA;
  logic       sig_R1W0;
  logic       channel;
  logic       spi_done;
  logic [7:0] read_data;
  logic       busy;

  agc_spi_sequencer_if bus ();

  agc_spi_sequencer #(
    .CS_SETUP (CS_SETUP),
    .CS_IDLE  (CS_IDLE),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .spi_clk   (clk),
    .reg_reset (rst_n),
    .req_if    (bus),
    .spi_cs    (spi_cs),
    .spi_mode  (spi_mode),
    .spi_dataA (spi_dataA),
    .sig_R1W0  (sig_R1W0),
    .channel   (channel),
    .spi_done  (spi_done),
    .read_data (read_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // done_dly: XFER cycle (0-based) in which the shifter raises spi_done,
  // -1 for never. exp_cs_low: cycles spi_cs is low (setup + xfer).
  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       chan;
    int         done_dly;
    logic [7:0] sh_rdata;
    logic [7:0] exp_mode;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_cs_low;
  } vec_t;

  vec_t vecs[6];

  // Runs one transaction from an IDLE negedge back to the next IDLE negedge.
  task automatic run_vec(input int idx, input vec_t v);
    int   cyc;
    int   cs_low;
    int   hold;
    logic got_rsp;
    logic stable_ok;
    logic pulse_ok;
    logic cs_hi_ok;
    check("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_rw    = v.rw;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_chan  = v.chan;
    bus.req_valid = 1'b1;
    read_data     = v.sh_rdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("cs_low_after_accept", {31'd0, spi_cs}, 32'd0);
    check("spi_mode", {24'd0, spi_mode}, {24'd0, v.exp_mode});
    check("spi_dataA", {24'd0, spi_dataA}, {24'd0, v.wdata});
    check("sig_R1W0", {31'd0, sig_R1W0}, {31'd0, v.rw});
    check("channel", {31'd0, channel}, {31'd0, v.chan});
    check("ready_busy", {31'd0, bus.req_ready}, 32'd0);
    check("busy", {31'd0, busy}, 32'd1);

    cs_low = 0; cyc = 0; got_rsp = 1'b0; stable_ok = 1'b1;
    while (!got_rsp && cyc < CS_SETUP + TIMEOUT + 8) begin
      if (bus.rsp_valid) begin
        got_rsp = 1'b1;
      end else begin
        if (spi_cs == 1'b0) begin
          cs_low++;
          if (spi_mode !== v.exp_mode || spi_dataA !== v.wdata ||
              sig_R1W0 !== v.rw || channel !== v.chan)
            stable_ok = 1'b0;
        end
        if (v.done_dly >= 0 && cs_low == CS_SETUP + 1 + v.done_dly)
          spi_done = 1'b1;
        @(negedge clk);
        cyc++;
      end
    end
    spi_done = 1'b0;
    check("rsp_seen", {31'd0, got_rsp}, 32'd1);
    check("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, v.exp_rdata});
    check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
    check("cs_high_at_rsp", {31'd0, spi_cs}, 32'd1);
    check("cs_low_cycles", cs_low, v.exp_cs_low);
    check("cmd_stable", {31'd0, stable_ok}, 32'd1);

    hold = 0; pulse_ok = 1'b1; cs_hi_ok = 1'b1;
    while (busy && hold < CS_IDLE + 8) begin
      if (spi_cs !== 1'b1 || bus.req_ready !== 1'b0) cs_hi_ok = 1'b0;
      if (hold > 0 && bus.rsp_valid !== 1'b0) pulse_ok = 1'b0;
      hold++;
      @(negedge clk);
    end
    check("hold_cycles", hold, CS_IDLE);
    check("rsp_one_cycle", {31'd0, pulse_ok}, 32'd1);
    check("hold_cs_ready", {31'd0, cs_hi_ok}, 32'd1);
    check("ready_after", {31'd0, bus.req_ready}, 32'd1);
    check("rdata_held", {24'd0, bus.rsp_rdata}, {24'd0, v.exp_rdata});
    check("err_held", {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
    $display("txn %0d: rw=%0d addr=0x%02h mode=0x%02h rdata=0x%02h err=%0d cs_low=%0d hold=%0d",
             idx, v.rw, v.addr, spi_mode, bus.rsp_rdata, bus.rsp_err, cs_low, hold);
  endtask

  initial begin
    int   cyc;
    int   falls;
    int   gap;
    int   t1;
    int   t2;
    int   rsp_cnt;
    logic prev_cs;
    logic ready_ok;
    logic quiet_ok;
    logic [7:0] mode1;
    logic [7:0] mode2;
    logic [7:0] rdata1;

    //        rw    addr   wdata  ch  dly  shifter expmode exprd  err cs_low
    vecs[0] = '{1'b1, 7'h03, 8'h00, 1'b1, 0,  8'h5C, 8'h83, 8'h5C, 1'b0, 3};
    vecs[1] = '{1'b0, 7'h15, 8'hA5, 1'b0, 3,  8'h77, 8'h15, 8'h00, 1'b0, 6};
    vecs[2] = '{1'b0, 7'h7F, 8'h3C, 1'b1, -1, 8'h11, 8'h7F, 8'h00, 1'b1, 66};
    vecs[3] = '{1'b1, 7'h40, 8'h00, 1'b0, 63, 8'hC3, 8'hC0, 8'hC3, 1'b0, 66};
    vecs[4] = '{1'b1, 7'h00, 8'h12, 1'b1, 1,  8'hFF, 8'h80, 8'hFF, 1'b0, 4};
    vecs[5] = '{1'b1, 7'h2A, 8'h00, 1'b0, -1, 8'h66, 8'hAA, 8'h00, 1'b1, 66};

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 7'h00;
    bus.req_wdata = 8'h00;
    bus.req_chan  = 1'b0;
    spi_done      = 1'b0;
    read_data     = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cs", {31'd0, spi_cs}, 32'd1);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    check("rst_mode", {24'd0, spi_mode}, 32'd0);
    check("rst_dataA", {24'd0, spi_dataA}, 32'd0);
    check("rst_r1w0", {31'd0, sig_R1W0}, 32'd0);
    check("rst_channel", {31'd0, channel}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Back-to-back: req_valid held across two requests, shifter always done.
    spi_done      = 1'b1;
    read_data     = 8'h99;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 7'h11;
    bus.req_wdata = 8'h4E;
    bus.req_chan  = 1'b0;
    bus.req_valid = 1'b1;
    falls = 0; gap = 0; t1 = 0; t2 = 0; rsp_cnt = 0; cyc = 0;
    prev_cs = 1'b1; ready_ok = 1'b1; mode1 = 8'h00; mode2 = 8'h00; rdata1 = 8'h00;
    while (falls < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (prev_cs && !spi_cs) begin
        falls++;
        if (falls == 1) begin
          t1 = cyc; mode1 = spi_mode;
          bus.req_rw = 1'b1; bus.req_addr = 7'h22;
        end else begin
          t2 = cyc; mode2 = spi_mode;
          bus.req_valid = 1'b0;
        end
      end
      if (spi_cs && falls == 1) gap++;
      if (bus.rsp_valid) begin rsp_cnt++; rdata1 = bus.rsp_rdata; end
      if (busy && bus.req_ready) ready_ok = 1'b0;
      prev_cs = spi_cs;
    end
    check("b2b_two_accepts", falls, 2);
    check("b2b_mode1", {24'd0, mode1}, 32'h11);
    check("b2b_mode2", {24'd0, mode2}, 32'hA2);
    check("b2b_period", t2 - t1, 1 + CS_SETUP + 1 + CS_IDLE);
    check("b2b_gap_ge_idle", {31'd0, gap >= CS_IDLE}, 32'd1);
    check("b2b_first_rsp", rsp_cnt, 1);
    check("b2b_first_rdata", {24'd0, rdata1}, 32'h00);
    check("b2b_ready_held_off", {31'd0, ready_ok}, 32'd1);
    cyc = 0; rsp_cnt = 0;
    while (rsp_cnt == 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (bus.rsp_valid) begin rsp_cnt++; rdata1 = bus.rsp_rdata; end
    end
    check("b2b_second_rsp", rsp_cnt, 1);
    check("b2b_second_rdata", {24'd0, rdata1}, 32'h99);
    spi_done = 1'b0;
    quiet_ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (falls == 2 && !busy && !spi_cs) quiet_ok = 1'b0;
      if (!spi_cs && !busy) quiet_ok = 1'b0;
    end
    check("b2b_no_third", {31'd0, quiet_ok && !busy && spi_cs}, 32'd1);
    $display("txn b2b: period=%0d gap=%0d mode1=0x%02h mode2=0x%02h rdata2=0x%02h",
             t2 - t1, gap, mode1, mode2, rdata1);

    // Reset asserted mid-XFER.
    bus.req_rw    = 1'b1;
    bus.req_addr  = 7'h05;
    bus.req_wdata = 8'h00;
    bus.req_chan  = 1'b1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (CS_SETUP + 3) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_cs_low", {31'd0, spi_cs}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_cs_high", {31'd0, spi_cs}, 32'd1);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_ready", {31'd0, bus.req_ready}, 32'd1);
    check("async_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || spi_cs !== 1'b1 || bus.req_ready !== 1'b1) quiet_ok = 1'b0;
    end
    check("reset_drop_silent", {31'd0, quiet_ok}, 32'd1);
    $display("txn reset_mid_xfer: cs=%0d ready=%0d rsp_valid=%0d", spi_cs, bus.req_ready, bus.rsp_valid);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
